// File: rtl/output_rr_arbiter_if.sv
// Handshake bundle between the four input-port controllers, the arbiter and the downstream link.
// The arbiter takes the slave side; the requesters and the downstream sink together take the master side.
interface output_rr_arbiter_if #(
   parameter int WIDTH_PACKET = 57,
   parameter int CNT_WIDTH    = 16
);
   logic [3:0]              in_valid;
   logic [WIDTH_PACKET-1:0] in_data0;
   logic [WIDTH_PACKET-1:0] in_data1;
   logic [WIDTH_PACKET-1:0] in_data2;
   logic [WIDTH_PACKET-1:0] in_data3;
   logic [3:0]              in_ready;
   logic                    out_valid;
   logic [WIDTH_PACKET-1:0] out_data;
   logic [1:0]              out_src;
   logic                    out_ready;
   logic [CNT_WIDTH-1:0]    pkt_count;

   modport master (
      output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
      input  in_ready, out_valid, out_data, out_src, pkt_count
   );

   modport slave (
      input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
      output in_ready, out_valid, out_data, out_src, pkt_count
   );
endinterface

// File: rtl/output_rr_arbiter.sv
// 4:1 rotating-priority arbiter feeding a one-entry output buffer; 1 cycle from grant to out_valid.
// A full buffer with out_ready low drops every in_ready; drain and refill may share a cycle.
module output_rr_arbiter #(
   parameter int WIDTH_PACKET = 57,
   parameter int CNT_WIDTH    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   output_rr_arbiter_if.slave io_bus
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t                  r_state;
   logic [1:0]              r_ptr;
   logic [WIDTH_PACKET-1:0] r_out_data;
   logic [1:0]              r_out_src;
   logic [CNT_WIDTH-1:0]    r_pkt_count;

   logic                    w_can_accept;
   logic                    w_win_vld;
   logic [1:0]              w_win;
   logic [1:0]              w_idx;
   logic                    w_in_xfer;
   logic                    w_out_xfer;
   logic [WIDTH_PACKET-1:0] w_win_data;

   assign w_can_accept = (r_state == EMPTY) || io_bus.out_ready;

   // Scan from the farthest offset back to ptr so the nearest requester overrides.
   always_comb begin
      w_win_vld = 1'b0;
      w_win     = 2'd0;
      w_idx     = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         w_idx = r_ptr + 2'(k);
         if (io_bus.in_valid[w_idx]) begin
            w_win_vld = 1'b1;
            w_win     = w_idx;
         end
      end
   end

   always_comb begin
      w_win_data = io_bus.in_data0;
      case (w_win)
         2'd0:    w_win_data = io_bus.in_data0;
         2'd1:    w_win_data = io_bus.in_data1;
         2'd2:    w_win_data = io_bus.in_data2;
         default: w_win_data = io_bus.in_data3;
      endcase
   end

   // rst_n gates the grant because the empty buffer would otherwise accept during reset.
   assign w_in_xfer  = w_win_vld && w_can_accept && rst_n;
   assign w_out_xfer = (r_state == FULL) && io_bus.out_ready;

   assign io_bus.in_ready  = w_in_xfer ? (4'b0001 << w_win) : 4'b0000;
   assign io_bus.out_valid = (r_state == FULL);
   assign io_bus.out_data  = r_out_data;
   assign io_bus.out_src   = r_out_src;
   assign io_bus.pkt_count = r_pkt_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= EMPTY;
         r_ptr       <= 2'd0;
         r_out_data  <= '0;
         r_out_src   <= 2'd0;
         r_pkt_count <= '0;
      end else begin
         if (w_in_xfer) begin
            r_state    <= FULL;
            r_out_data <= w_win_data;
            r_out_src  <= w_win;
            r_ptr      <= w_win + 2'd1;
         end else if (w_out_xfer) begin
            r_state <= EMPTY;
         end
         if (w_out_xfer) begin
            r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
         end
      end
   end
endmodule

// File: tb/tb_output_rr_arbiter.sv
// Bench for output_rr_arbiter: vector rows carry hand-derived grants, a queue holds the packet
// expected in the output buffer, and reset corners are driven as separate sequences.
module tb_output_rr_arbiter;
   localparam int WP = 57;
   localparam int CW = 4;

   typedef struct {
      logic [3:0]    iv;
      logic          ordy;
      logic [3:0]    exp_rdy;
      logic [WP-1:0] dat;
   } vec_t;

   typedef struct {
      logic [1:0]    src;
      logic [WP-1:0] dat;
   } pkt_t;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   int            n_cmp   = 0;
   int            n_err   = 0;
   vec_t          tbl[$];
   pkt_t          sb_q[$];
   logic          exp_full = 1'b0;
   logic [CW-1:0] exp_cnt  = '0;
   int            mid_row  = 0;

   output_rr_arbiter_if #(.WIDTH_PACKET(WP), .CNT_WIDTH(CW)) bus ();

   output_rr_arbiter #(.WIDTH_PACKET(WP), .CNT_WIDTH(CW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic void add(input logic [3:0] iv, input logic ordy,
                               input logic [3:0] er, input logic [WP-1:0] dat);
      vec_t v;
      v.iv      = iv;
      v.ordy    = ordy;
      v.exp_rdy = er;
      v.dat     = dat;
      tbl.push_back(v);
   endfunction

   task automatic drive_data(input logic [WP-1:0] dat);
      bus.in_data0 = dat;
      bus.in_data1 = dat + WP'(1);
      bus.in_data2 = dat + WP'(2);
      bus.in_data3 = dat + WP'(3);
   endtask

   // Called just after a falling edge; returns at the next falling edge.
   task automatic run_row(input vec_t v);
      pkt_t pk;
      bus.in_valid  = v.iv;
      bus.out_ready = v.ordy;
      drive_data(v.dat);
      #2;
      chk("out_valid", 64'(bus.out_valid), 64'(exp_full));
      if (exp_full) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: buffer expected full but no packet queued");
         end else begin
            chk("out_src", 64'(bus.out_src), 64'(sb_q[0].src));
            chk("out_data", 64'(bus.out_data), 64'(sb_q[0].dat));
         end
      end
      chk("in_ready", 64'(bus.in_ready), 64'(v.exp_rdy));
      chk("pkt_count", 64'(bus.pkt_count), 64'(exp_cnt));
      if (exp_full && v.ordy) begin
         if (sb_q.size() != 0) void'(sb_q.pop_front());
         exp_cnt  = exp_cnt + CW'(1);
         exp_full = 1'b0;
      end
      for (int p = 0; p < 4; p++) begin
         if (v.exp_rdy[p]) begin
            pk.src = 2'(p);
            pk.dat = v.dat + WP'(p);
            sb_q.push_back(pk);
            exp_full = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   // Buffer is full with ptr=3; reset is asserted between clock edges.
   task automatic mid_reset();
      bus.in_valid  = 4'b1001;
      bus.out_ready = 1'b0;
      #1;
      chk("pre_rst_out_valid", 64'(bus.out_valid), 64'(exp_full));
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("async_rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("async_rst_pkt_count", 64'(bus.pkt_count), 64'd0);
      chk("async_rst_out_src", 64'(bus.out_src), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      sb_q.delete();
      exp_full = 1'b0;
      exp_cnt  = '0;
   endtask

   initial begin
      bus.in_valid  = 4'hF;
      bus.out_ready = 1'b1;
      drive_data('0);

      for (int k = 0; k < 9; k++) add(4'hF, 1'b1, 4'(1 << (k % 4)), WP'(0));
      add(4'b0010, 1'b1, 4'b0010, WP'('h10));
      add(4'b1010, 1'b1, 4'b1000, WP'('h10));
      add(4'b1010, 1'b1, 4'b0010, WP'('h10));
      add(4'b1010, 1'b1, 4'b1000, WP'('h10));
      add(4'b0001, 1'b1, 4'b0001, WP'(5));
      for (int k = 0; k < 5; k++) add(4'b0100, 1'b0, 4'b0000, WP'(5));
      add(4'b0100, 1'b1, 4'b0100, WP'(5));
      mid_row = tbl.size();
      add(4'b1001, 1'b1, 4'b0001, WP'('h20));
      for (int k = 0; k < 18; k++) add(4'hF, 1'b1, 4'(1 << ((1 + k) % 4)), WP'('h40));
      add(4'b0000, 1'b1, 4'b0000, WP'('h40));
      add(4'b0000, 1'b1, 4'b0000, WP'('h40));

      repeat (3) @(negedge clk);
      #2;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_pkt_count", 64'(bus.pkt_count), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      chk("rst_out_src", 64'(bus.out_src), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         if (i == mid_row) mid_reset();
         run_row(tbl[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/output_rr_arbiter.md
# output_rr_arbiter

Clocked 4:1 round-robin output-port arbiter for the NoC router. It shares one router output link between the four input-port controllers, each offering one 57-bit packet per handshake. It registers the winner into a one-entry output buffer and forwards it downstream. Fairness is strict rotating priority: a continuously requesting port waits at most 3 grants.

## Interface
- WIDTH_PACKET, 57, packet width in bits (one flit per packet)
- CNT_WIDTH, 16, width of the forwarded-packet counter
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid[3:0]  input  4  per-port request; bit i = port i holds a packet
- in_data0..in_data3  input  WIDTH_PACKET each  packet from port 0..3
- in_ready[3:0]  output  4  per-port accept; one-hot or zero
- out_valid  output  1  output buffer holds a packet
- out_data  output  WIDTH_PACKET  buffered packet
- out_src  output  2  index of the port that supplied out_data
- out_ready  input  1  downstream accepts out_data this cycle
- pkt_count  output  CNT_WIDTH  packets forwarded downstream, wrapping

## Operation
- Transfer rules:
  - Input transfer: in_valid[i] & in_ready[i] in the same cycle.
  - Output transfer: out_valid & out_ready.
- Buffer states: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_accept = ~out_valid | out_ready, so a drain and a refill can happen in the same cycle.
- Arbitration (combinational):
  - Search in_valid starting at ptr, then ptr+1, ptr+2, ptr+3 (mod 4).
  - The first set bit is the winner w.
  - in_ready[w] = can_accept. All other in_ready bits = 0.
  - If in_valid = 0, in_ready = 0.
- On an input transfer from port w:
  - out_data <= in_data_w
  - out_src <= w
  - out_valid <= 1
  - ptr <= (w+1) mod 4
- On an output transfer with no input transfer in the same cycle: out_valid <= 0. out_data and out_src hold their last values.
- On an output transfer, pkt_count increments by 1 and wraps from 2^CNT_WIDTH−1 to 0.
- ptr changes only on an input transfer. A stalled output (FULL, out_ready=0) freezes ptr, in_ready and the buffer.
- Requester rules:
  - A requester must hold in_valid and its data stable until accepted.
  - in_ready depends combinationally on in_valid, ptr, out_valid and out_ready. No combinational path from in_ready back to in_valid is permitted.
- Transitions:
  - EMPTY→FULL on an input transfer.
  - FULL→FULL on an input transfer, or when out_ready=0.
  - FULL→EMPTY on an output transfer with no input transfer.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_src=0, ptr=0, pkt_count=0.
- While rst_n is low, in_ready=0, because out_valid=0 and the arbiter output is gated by rst_n.
- Release of rst_n is synchronous to clk. The first grant is possible in the first cycle after release.
- Latency: input transfer at edge N makes the packet visible on out_data/out_valid after edge N.
- Throughput: 1 packet per cycle while out_ready=1.
- Reset asserted mid-operation: the buffered packet is discarded, no packet is counted, and ptr returns to 0.
- Simultaneous output transfer and input transfer: the buffer stays FULL with the new packet and pkt_count increments.
- Back-pressure: out_ready=0 while FULL forces in_ready=0 in that cycle.

## Test plan
- Reset values: hold rst_n low with all in_valid=1. Required: in_ready=0, out_valid=0, pkt_count=0. Release rst_n with in_data0..3 = 0,1,2,3. Required: port 0 wins first.
- Round-robin rotation: all four ports valid continuously, out_ready=1, data = port index. Required: out_src sequence 0,1,2,3,0,1… with one packet per cycle, and pkt_count=8 after 8 output transfers.
- Pointer skip: only ports 1 and 3 valid, ptr=2. Required: grants go 3, then 1, then 3. Port 0 and port 2 in_ready stay 0.
- Back-pressure: buffer FULL with 0x5, out_ready=0 for 5 cycles, port 2 valid with 0x7. Required: out_data stays 0x5, in_ready=0 and ptr unchanged for all 5 cycles. When out_ready=1, 0x7 loads in the same cycle and out_src=2.
- Counter wrap: CNT_WIDTH=4, forward 17 packets. Required: pkt_count reads 15 after 15 transfers, 0 after 16, and 1 after 17.
- Mid-operation reset: assert rst_n low asynchronously while FULL with ptr=3. Required: out_valid drops immediately without waiting for a clock edge. After release with ports 0 and 3 valid, port 0 is granted first.
